// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the RISC-V core (read/write) and the
// frame-buffer scanout reader (read-only).
//
// Round-robin arbitration with a combinational grant, a registered memory command and a
// READ_LAT-deep tag pipeline that routes each read return to the requester that issued it.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   c_req/c_we/c_adr/c_wdata  core request; held stable until c_gnt
//   c_gnt                     core request accepted this cycle
//   c_rvalid/c_rdata          core read return
//   v_req/v_adr               scanout read request; held stable until v_gnt
//   v_gnt                     scanout request accepted this cycle
//   v_rvalid/v_rdata          scanout read return
//   m_en/m_we/m_adr/m_wdata   registered memory command
//   m_rdata                   memory read data, valid READ_LAT cycles after the m_en cycle
module mem_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned READ_LAT = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  // core port
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_adr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  // scanout port
  input  logic          v_req,
  input  logic [AW-1:0] v_adr,
  output logic          v_gnt,
  output logic          v_rvalid,
  output logic [DW-1:0] v_rdata,
  // memory macro
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_adr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  // Requester identifiers, used both for the round-robin pointer and the read tags.
  localparam logic IdCore  = 1'b0;
  localparam logic IdVideo = 1'b1;

  logic                last_q;     // requester granted most recently
  logic                cmd_id_q;   // requester that owns the command currently on m_*
  logic [READ_LAT-1:0] rd_valid_q; // read tag pipeline: valid bits
  logic [READ_LAT-1:0] rd_id_q;    // read tag pipeline: requester ids

  // ---------------------------------------------------------------------------------------------
  // Arbitration: the core wins unless the scanout also requests and the core was served last.
  // ---------------------------------------------------------------------------------------------
  assign c_gnt = c_req & (~v_req | (last_q == IdVideo));
  assign v_gnt = v_req & ~c_gnt;

  // ---------------------------------------------------------------------------------------------
  // Command register and round-robin pointer.
  // m_adr/m_wdata deliberately hold on idle cycles so the macro address bus does not toggle.
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_en     <= 1'b0;
      m_we     <= 1'b0;
      m_adr    <= '0;
      m_wdata  <= '0;
      cmd_id_q <= IdCore;
      last_q   <= IdVideo;
    end else begin
      m_en <= c_gnt | v_gnt;
      if (c_gnt) begin
        m_we     <= c_we;
        m_adr    <= c_adr;
        m_wdata  <= c_wdata;
        cmd_id_q <= IdCore;
        last_q   <= IdCore;
      end else if (v_gnt) begin
        m_we     <= 1'b0;
        m_adr    <= v_adr;
        m_wdata  <= '0;
        cmd_id_q <= IdVideo;
        last_q   <= IdVideo;
      end else begin
        m_we <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Read tag pipeline. Stage 0 captures the command presented during the m_en cycle; after
  // READ_LAT cycles the tag reaches the tail in the same cycle the macro drives m_rdata.
  // Reset clears every tag, so reads in flight across a reset never produce rvalid.
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= '0;
      rd_id_q    <= '0;
    end else begin
      for (int i = READ_LAT - 1; i > 0; i--) begin
        rd_valid_q[i] <= rd_valid_q[i-1];
        rd_id_q[i]    <= rd_id_q[i-1];
      end
      rd_valid_q[0] <= m_en & ~m_we;
      rd_id_q[0]    <= cmd_id_q;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Read return: data is shared, the tail tag selects which requester sees rvalid.
  // ---------------------------------------------------------------------------------------------
  assign c_rvalid = rd_valid_q[READ_LAT-1] & (rd_id_q[READ_LAT-1] == IdCore);
  assign v_rvalid = rd_valid_q[READ_LAT-1] & (rd_id_q[READ_LAT-1] == IdVideo);
  assign c_rdata  = m_rdata;
  assign v_rdata  = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus a randomized run checked against a
// transaction-level model (grant rule, expected command, queue of expected read returns).
module tb_mem_arbiter;

  localparam int unsigned AW       = 32;
  localparam int unsigned DW       = 32;
  localparam int unsigned READ_LAT = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          c_req, c_we, c_gnt, c_rvalid;
  logic [AW-1:0] c_adr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          v_req, v_gnt, v_rvalid;
  logic [AW-1:0] v_adr;
  logic [DW-1:0] v_rdata;
  logic          m_en, m_we;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_wdata, m_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            due;
    logic          vid;
    logic [DW-1:0] data;
  } ret_t;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .READ_LAT(READ_LAT)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .c_req    (c_req),
    .c_we     (c_we),
    .c_adr    (c_adr),
    .c_wdata  (c_wdata),
    .c_gnt    (c_gnt),
    .c_rvalid (c_rvalid),
    .c_rdata  (c_rdata),
    .v_req    (v_req),
    .v_adr    (v_adr),
    .v_gnt    (v_gnt),
    .v_rvalid (v_rvalid),
    .v_rdata  (v_rdata),
    .m_en     (m_en),
    .m_we     (m_we),
    .m_adr    (m_adr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata)
  );

  // Power-on content of the memory for a word that was never written.
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    if (a == 32'h0000_0200) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  // Memory macro model: word-addressed, READ_LAT-cycle read pipe, random data when idle.
  logic [DW-1:0] mem_arr  [4096];
  bit            mem_wr   [4096];
  logic [DW-1:0] mem_pipe [READ_LAT];
  assign m_rdata = mem_pipe[READ_LAT-1];

  always @(posedge clk) begin
    for (int i = READ_LAT - 1; i > 0; i--) mem_pipe[i] <= mem_pipe[i-1];
    if (m_en && !m_we) mem_pipe[0] <= mem_wr[m_adr[13:2]] ? mem_arr[m_adr[13:2]] : init_word(m_adr);
    else mem_pipe[0] <= $urandom();
    if (m_en && m_we) begin
      mem_arr[m_adr[13:2]] <= m_wdata;
      mem_wr[m_adr[13:2]]  <= 1'b1;
    end
  end

  task automatic apply_reset();
    reset_n = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_adr = '0; c_wdata = '0;
    v_req = 1'b0; v_adr = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_adr = 32'h40; c_wdata = 32'h1234_5678;
    v_req = 1'b1; v_adr = 32'h80;
    @(negedge clk);
    checks++; if (c_gnt !== 1'b1) begin errors++; $display("FAIL rst_c_gnt got %b want 1", c_gnt); end
    checks++; if (v_gnt !== 1'b0) begin errors++; $display("FAIL rst_v_gnt got %b want 0", v_gnt); end
    @(posedge clk); @(negedge clk);
    checks++; if (m_en !== 1'b0) begin errors++; $display("FAIL rst_m_en got %b want 0", m_en); end
    checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL rst_m_we got %b want 0", m_we); end
    checks++; if (m_adr !== '0) begin errors++; $display("FAIL rst_m_adr got %h want 0", m_adr); end
    checks++; if (m_wdata !== '0) begin errors++; $display("FAIL rst_m_wdata got %h want 0", m_wdata); end
    checks++; if (c_rvalid !== 1'b0 || v_rvalid !== 1'b0) begin
      errors++; $display("FAIL rst_rvalid got c=%b v=%b want 0 0", c_rvalid, v_rvalid);
    end
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1 c_req = 1'b0; v_req = 1'b0;
    @(negedge clk);
    checks++; if (m_en !== 1'b1 || m_we !== 1'b0 || m_adr !== 32'h40) begin
      errors++; $display("FAIL rst_first_cmd got en=%b we=%b adr=%h want 1 0 00000040", m_en, m_we, m_adr);
    end
  endtask

  task automatic test_core_read();
    apply_reset();
    c_req = 1'b1; c_we = 1'b0; c_adr = 32'h200;
    @(negedge clk);
    checks++; if (c_gnt !== 1'b1) begin errors++; $display("FAIL crd_gnt got %b want 1", c_gnt); end
    @(posedge clk); #1 c_req = 1'b0;
    @(negedge clk);
    checks++; if (m_en !== 1'b1 || m_we !== 1'b0 || m_adr !== 32'h200) begin
      errors++; $display("FAIL crd_cmd got en=%b we=%b adr=%h want 1 0 00000200", m_en, m_we, m_adr);
    end
    @(posedge clk); @(negedge clk);
    checks++; if (c_rvalid !== 1'b0) begin errors++; $display("FAIL crd_early got %b want 0", c_rvalid); end
    @(posedge clk); @(negedge clk);
    checks++; if (c_rvalid !== 1'b1 || c_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL crd_ret got rv=%b data=%h want 1 deadbeef", c_rvalid, c_rdata);
    end
    checks++; if (v_rvalid !== 1'b0) begin errors++; $display("FAIL crd_v_rvalid got %b want 0", v_rvalid); end
    @(posedge clk); @(negedge clk);
    checks++; if (c_rvalid !== 1'b0) begin errors++; $display("FAIL crd_late got %b want 0", c_rvalid); end
  endtask

  task automatic test_core_write();
    apply_reset();
    c_req = 1'b1; c_we = 1'b1; c_adr = 32'h104; c_wdata = 32'h0000_AB00;
    @(negedge clk);
    checks++; if (c_gnt !== 1'b1) begin errors++; $display("FAIL cwr_gnt got %b want 1", c_gnt); end
    @(posedge clk); #1 c_req = 1'b0; c_we = 1'b0;
    @(negedge clk);
    checks++; if (m_en !== 1'b1 || m_we !== 1'b1 || m_adr !== 32'h104 || m_wdata !== 32'h0000_AB00) begin
      errors++; $display("FAIL cwr_cmd got en=%b we=%b adr=%h wd=%h want 1 1 00000104 0000ab00",
                         m_en, m_we, m_adr, m_wdata);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (c_rvalid !== 1'b0 || v_rvalid !== 1'b0 || m_we !== 1'b0) begin
        errors++; $display("FAIL cwr_quiet%0d got rv=%b/%b we=%b want 0", k, c_rvalid, v_rvalid, m_we);
      end
    end
  endtask

  task automatic test_conflict();
    logic          exp_c;
    logic [AW-1:0] exp_a;
    int            j;
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      if (k < 6) begin
        c_req = 1'b1; v_req = 1'b1;
        c_adr = 32'h1000 + 4 * ((k + 1) / 2);
        v_adr = 32'h2000 + 4 * (k / 2);
      end else begin
        c_req = 1'b0; v_req = 1'b0;
      end
      @(negedge clk);
      if (k < 6) begin
        exp_c = (k % 2 == 0);
        checks++; if (c_gnt !== exp_c || v_gnt !== !exp_c) begin
          errors++; $display("FAIL rr_gnt%0d got c=%b v=%b want %b %b", k, c_gnt, v_gnt, exp_c, !exp_c);
        end
      end
      if (k >= 1 && k <= 6) begin
        j = k - 1;
        exp_a = (j % 2 == 0) ? 32'h1000 + 4 * (j / 2) : 32'h2000 + 4 * (j / 2);
        checks++; if (m_en !== 1'b1 || m_adr !== exp_a) begin
          errors++; $display("FAIL rr_cmd%0d got en=%b adr=%h want 1 %h", k, m_en, m_adr, exp_a);
        end
      end else begin
        checks++; if (m_en !== 1'b0) begin errors++; $display("FAIL rr_idle%0d got %b want 0", k, m_en); end
      end
      if (k >= 3 && k <= 8) begin
        j = k - 3;
        exp_c = (j % 2 == 0);
        exp_a = exp_c ? 32'h1000 + 4 * (j / 2) : 32'h2000 + 4 * (j / 2);
        checks++; if (c_rvalid !== exp_c || v_rvalid !== !exp_c) begin
          errors++; $display("FAIL rr_rv%0d got c=%b v=%b want %b %b", k, c_rvalid, v_rvalid, exp_c, !exp_c);
        end
        checks++; if ((exp_c ? c_rdata : v_rdata) !== init_word(exp_a)) begin
          errors++; $display("FAIL rr_data%0d got %h want %h", k, exp_c ? c_rdata : v_rdata, init_word(exp_a));
        end
      end else begin
        checks++; if (c_rvalid !== 1'b0 || v_rvalid !== 1'b0) begin
          errors++; $display("FAIL rr_norv%0d got c=%b v=%b want 0 0", k, c_rvalid, v_rvalid);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] exp_a;
    apply_reset();
    for (int k = 0; k < 7; k++) begin
      if (k < 3) begin v_req = 1'b1; v_adr = 32'h400 + 4 * k; end
      else v_req = 1'b0;
      @(negedge clk);
      if (k < 3) begin
        checks++; if (v_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt%0d got %b want 1", k, v_gnt); end
      end
      if (k >= 3 && k <= 5) begin
        exp_a = 32'h400 + 4 * (k - 3);
        checks++; if (v_rvalid !== 1'b1 || v_rdata !== init_word(exp_a)) begin
          errors++; $display("FAIL b2b_ret%0d got rv=%b data=%h want 1 %h", k, v_rvalid, v_rdata, init_word(exp_a));
        end
      end else begin
        checks++; if (v_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_norv%0d got %b want 0", k, v_rvalid); end
      end
      checks++; if (c_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_c_rv%0d got %b want 0", k, c_rvalid); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    v_req = 1'b1; v_adr = 32'h600;
    @(negedge clk);
    checks++; if (v_gnt !== 1'b1) begin errors++; $display("FAIL mid_gnt got %b want 1", v_gnt); end
    @(posedge clk);
    #1 v_req = 1'b0; reset_n = 1'b0;
    #2 reset_n = 1'b1;
    @(negedge clk);
    checks++; if (m_en !== 1'b0) begin errors++; $display("FAIL mid_m_en got %b want 0", m_en); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (v_rvalid !== 1'b0 || c_rvalid !== 1'b0) begin
        errors++; $display("FAIL mid_norv%0d got v=%b c=%b want 0 0", k, v_rvalid, c_rvalid);
      end
      @(posedge clk); @(negedge clk);
    end
    @(posedge clk); #1 c_req = 1'b1; c_we = 1'b0; c_adr = 32'h700;
    @(negedge clk);
    checks++; if (c_gnt !== 1'b1) begin errors++; $display("FAIL mid_c_gnt got %b want 1", c_gnt); end
    @(posedge clk); #1 c_req = 1'b0;
    @(negedge clk);
    checks++; if (m_en !== 1'b1 || m_adr !== 32'h700) begin
      errors++; $display("FAIL mid_c_cmd got en=%b adr=%h want 1 00000700", m_en, m_adr);
    end
    @(posedge clk); @(negedge clk);
    checks++; if (c_rvalid !== 1'b0) begin errors++; $display("FAIL mid_c_early got %b want 0", c_rvalid); end
    @(posedge clk); @(negedge clk);
    checks++; if (c_rvalid !== 1'b1 || c_rdata !== init_word(32'h700)) begin
      errors++; $display("FAIL mid_c_ret got rv=%b data=%h want 1 %h", c_rvalid, c_rdata, init_word(32'h700));
    end
  endtask

  // Randomized traffic against a transaction model: who should be granted, what command should
  // appear next cycle, and which return is due in which cycle with which data.
  task automatic test_random();
    ret_t          pend[$];
    ret_t          r;
    logic [DW-1:0] ref_mem [16];
    logic          ref_last_vid;
    logic          ec, ev, pc, pv;
    logic          exp_en, exp_we, exp_crv, exp_vrv;
    logic [AW-1:0] exp_adr;
    logic [DW-1:0] exp_wdata, exp_data;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(32'h3000 + 4 * i);
    apply_reset();
    ref_last_vid = 1'b1;
    exp_en = 1'b0; exp_we = 1'b0; exp_adr = '0; exp_wdata = '0;
    pc = 1'b0; pv = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      // Requesters: pick a new request after a grant or when idle; rarely drop a waiting one.
      if (!c_req || pc) begin
        c_req   = ($urandom_range(0, 99) < 60);
        c_we    = ($urandom_range(0, 2) == 0);
        c_adr   = 32'h3000 + 4 * $urandom_range(0, 15);
        c_wdata = $urandom();
      end else if ($urandom_range(0, 19) == 0) c_req = 1'b0;
      if (!v_req || pv) begin
        v_req = ($urandom_range(0, 99) < 70);
        v_adr = 32'h3000 + 4 * $urandom_range(0, 15);
      end else if ($urandom_range(0, 19) == 0) v_req = 1'b0;
      @(negedge clk);
      ec = c_req && (!v_req || ref_last_vid);
      ev = v_req && !ec;
      checks++; if (c_gnt !== ec || v_gnt !== ev) begin
        errors++; $display("FAIL rnd_gnt c%0d got c=%b v=%b want %b %b", cyc, c_gnt, v_gnt, ec, ev);
      end
      checks++; if (m_en !== exp_en || m_we !== exp_we || m_adr !== exp_adr || m_wdata !== exp_wdata) begin
        errors++; $display("FAIL rnd_cmd c%0d got %b %b %h %h want %b %b %h %h", cyc,
                           m_en, m_we, m_adr, m_wdata, exp_en, exp_we, exp_adr, exp_wdata);
      end
      exp_crv = 1'b0; exp_vrv = 1'b0; exp_data = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r = pend.pop_front();
        exp_crv = !r.vid; exp_vrv = r.vid; exp_data = r.data;
      end
      checks++; if (c_rvalid !== exp_crv || v_rvalid !== exp_vrv) begin
        errors++; $display("FAIL rnd_rv c%0d got c=%b v=%b want %b %b", cyc, c_rvalid, v_rvalid, exp_crv, exp_vrv);
      end
      if (exp_crv || exp_vrv) begin
        checks++; if ((exp_crv ? c_rdata : v_rdata) !== exp_data) begin
          errors++; $display("FAIL rnd_data c%0d got %h want %h", cyc, exp_crv ? c_rdata : v_rdata, exp_data);
        end
      end
      // Advance the model to the next cycle.
      exp_en = ec || ev;
      exp_we = ec && c_we;
      if (ec) begin
        exp_adr = c_adr; exp_wdata = c_wdata; ref_last_vid = 1'b0;
        if (c_we) ref_mem[c_adr[5:2]] = c_wdata;
        else pend.push_back('{due: cyc + 1 + READ_LAT, vid: 1'b0, data: ref_mem[c_adr[5:2]]});
      end else if (ev) begin
        exp_adr = v_adr; exp_wdata = '0; ref_last_vid = 1'b1;
        pend.push_back('{due: cyc + 1 + READ_LAT, vid: 1'b1, data: ref_mem[v_adr[5:2]]});
      end
      pc = ec; pv = ev;
      @(posedge clk); #1;
    end
    checks++; if (pend.size() > READ_LAT + 1) begin
      errors++; $display("FAIL rnd_pending got %0d want <= %0d", pend.size(), READ_LAT + 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_adr = '0; c_wdata = '0;
    v_req = 1'b0; v_adr = '0;
    #1;
    test_reset();
    test_core_read();
    test_core_write();
    test_conflict();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
